fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter PC_BASE, default 32'h0000_3000, meaning the reset fetch address.
REQ-002 The block SHALL have parameter EXC_ENTRY, default 32'h0000_4180, meaning the exception handler address.
REQ-003 The block SHALL have parameters PC_MIN, default 32'h0000_3000, and PC_MAX, default 32'h0000_6ffc, meaning the legal fetch window.
REQ-004 The block SHALL have port clk  in  1  single clock, rising edge.
REQ-005 The block SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port stall  in  1  hazard stall request from decode.
REQ-007 The block SHALL have port br_valid  in  1  taken branch/jump resolved in decode.
REQ-008 The block SHALL have port br_target  in  32  branch/jump target.
REQ-009 The block SHALL have port exc_valid  in  1  exception accepted by CP0.
REQ-010 The block SHALL have port eret_valid  in  1  eret accepted.
REQ-011 The block SHALL have port epc  in  32  return address for eret.
REQ-012 The block SHALL have port f_pc  in  32  current fetch PC from the IFU.
REQ-013 The block SHALL have port ifu_en  out  1  IFU PC write enable.
REQ-014 The block SHALL have port npc  out  32  next PC presented to the IFU.
REQ-015 The block SHALL have port flush_fd  out  1  clear the F/D pipeline register.
REQ-016 The block SHALL have port f_exccode  out  5  fetch exception code, 5'd4 (AdEL) or 5'd0.
REQ-017 The block SHALL have port state  out  2  FSM state: RUN=0, HOLD=1, HOLD_PEND=2.
REQ-018 The block SHALL have port stall_cnt  out  16  cycles with ifu_en=0, saturating.
REQ-019 The block SHALL have port redir_cnt  out  16  exc+eret redirects, wrapping.

Function
REQ-020 The block SHALL resolve events with priority exc_valid > eret_valid > branch (br_valid or pending) > stall > sequential.
REQ-021 On exc_valid the block SHALL drive npc=EXC_ENTRY, ifu_en=1 and flush_fd=1 even if stall=1, clear pending, and go to RUN.
REQ-022 On eret_valid without exc_valid the block SHALL drive npc=epc, ifu_en=1 and flush_fd=1 even if stall=1, clear pending, and go to RUN.
REQ-023 In RUN with br_valid=1 and stall=0 the block SHALL drive npc=br_target, ifu_en=1 and flush_fd=0, because the delay slot is kept.
REQ-024 In RUN with br_valid=1 and stall=1 the block SHALL drive ifu_en=0, latch br_target into pending, and go to HOLD_PEND.
REQ-025 In RUN or HOLD with stall=1 and no branch the block SHALL drive ifu_en=0 and go to HOLD.
REQ-026 In RUN or HOLD with no event the block SHALL drive npc=f_pc+4 (modulo 2^32, wrapping) and ifu_en=1, ending in RUN.
REQ-027 In HOLD_PEND with stall=1 the block SHALL drive ifu_en=0; if br_valid=1, pending SHALL be overwritten with br_target (latest wins).
REQ-028 In HOLD_PEND with stall=0 the block SHALL drive ifu_en=1 and npc=(br_valid ? br_target : pending), then clear pending and go to RUN.
REQ-029 All npc/ifu_en/flush_fd outputs SHALL be combinational from the current state and inputs, with zero-cycle latency; state, pending and the counters SHALL update on the rising edge of clk.
REQ-030 f_exccode SHALL be 5'd4 when f_pc[1:0]!=0, f_pc<PC_MIN or f_pc>PC_MAX, and 5'd0 otherwise; it SHALL be combinational and SHALL not affect the FSM.
REQ-031 stall_cnt SHALL increment on each clock with ifu_en=0 and SHALL hold at 16'hFFFF.
REQ-032 redir_cnt SHALL increment on each clock with exc_valid or eret_valid and SHALL wrap from 16'hFFFF to 0.
REQ-033 Simultaneous exc_valid and eret_valid SHALL count once and follow the exception path.

Reset
REQ-034 While reset=1 the block SHALL force state=RUN, pending=0, stall_cnt=0, redir_cnt=0, ifu_en=0, npc=PC_BASE and flush_fd=0, asynchronously and independent of clk.
REQ-035 Reset asserted in HOLD_PEND SHALL discard the pending target, and the first cycle after release SHALL behave as RUN.

Verification
REQ-036 The bench SHALL cover: reset released, f_pc=0x3000, no events -> ifu_en=1, npc=0x3004, state=0.
REQ-037 The bench SHALL cover: br_valid=1, br_target=0x3100, stall=1 for 3 cycles, then stall=0 with br_valid=0 -> ifu_en=0 for 3 cycles, state=2, then npc=0x3100, ifu_en=1, state=0, stall_cnt=3.
REQ-038 The bench SHALL cover: exc_valid=1 together with stall=1 and br_valid=1 -> npc=0x4180, ifu_en=1, flush_fd=1, state=0, redir_cnt+1.
REQ-039 The bench SHALL cover: eret_valid=1, epc=0x3ffc -> npc=0x3ffc, flush_fd=1; then f_pc=0x3002 -> f_exccode=4; then f_pc=0x7000 -> f_exccode=4.
REQ-040 The bench SHALL cover: f_pc=0xFFFF_FFFC, no events -> npc=0x0000_0000, f_exccode=4.
REQ-041 The bench SHALL cover: reset pulsed mid-cycle in HOLD_PEND -> outputs reach their reset values before the next clk edge, pending lost, stall_cnt=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: picks the next PC from exception, eret, branch,
// stall and sequential sources, and holds a branch target across decode stalls.
module fetch_ctrl #(
  parameter logic [31:0] PC_BASE   = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PC_MIN    = 32'h0000_3000,
  parameter logic [31:0] PC_MAX    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic [31:0] f_pc,
  output logic        ifu_en,
  output logic [31:0] npc,
  output logic        flush_fd,
  output logic [4:0]  f_exccode,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] redir_cnt
);

  // state     | meaning
  // RUN       | fetching normally
  // HOLD      | decode stall, no branch outstanding
  // HOLD_PEND | decode stall with a taken branch target waiting in r_pending
  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_HOLD_PEND = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pending;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_redir_cnt;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pending_nxt;
  logic        w_ifu_en;
  logic [31:0] w_npc;
  logic        w_flush;
  logic        w_redir;

  assign w_redir = exc_valid | eret_valid;

  always_comb begin
    w_npc         = f_pc + 32'd4;
    w_ifu_en      = 1'b1;
    w_flush       = 1'b0;
    w_state_nxt   = ST_RUN;
    w_pending_nxt = r_pending;
    if (reset) begin
      w_npc         = PC_BASE;
      w_ifu_en      = 1'b0;
      w_pending_nxt = 32'd0;
    end else if (exc_valid) begin
      w_npc         = EXC_ENTRY;
      w_flush       = 1'b1;
      w_pending_nxt = 32'd0;
    end else if (eret_valid) begin
      w_npc         = epc;
      w_flush       = 1'b1;
      w_pending_nxt = 32'd0;
    end else if (r_state == ST_HOLD_PEND) begin
      if (stall) begin
        w_ifu_en    = 1'b0;
        w_state_nxt = ST_HOLD_PEND;
        if (br_valid) w_pending_nxt = br_target;
      end else begin
        w_npc         = br_valid ? br_target : r_pending;
        w_pending_nxt = 32'd0;
      end
    end else if (br_valid) begin
      // delay slot stays in F/D, so a plain branch never flushes
      if (stall) begin
        w_ifu_en      = 1'b0;
        w_pending_nxt = br_target;
        w_state_nxt   = ST_HOLD_PEND;
      end else begin
        w_npc = br_target;
      end
    end else if (stall) begin
      w_ifu_en    = 1'b0;
      w_state_nxt = ST_HOLD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pending   <= 32'd0;
      r_stall_cnt <= 16'd0;
      r_redir_cnt <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (!w_ifu_en && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_redir) r_redir_cnt <= r_redir_cnt + 16'd1;
    end
  end

  assign ifu_en    = w_ifu_en;
  assign npc       = w_npc;
  assign flush_fd  = w_flush;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign redir_cnt = r_redir_cnt;

  // address-error check is informational only and never steers the FSM
  assign f_exccode = ((f_pc[1:0] != 2'b00) || (f_pc < PC_MIN) || (f_pc > PC_MAX)) ? 5'd4 : 5'd0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// compared against a priority-rule reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_valid, exc_valid, eret_valid;
  logic [31:0] br_target, epc, f_pc;
  logic        ifu_en, flush_fd;
  logic [31:0] npc;
  logic [4:0]  f_exccode;
  logic [1:0]  state;
  logic [15:0] stall_cnt, redir_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: "a branch target is waiting", "decode is holding us"
  bit          m_pend_v;
  logic [31:0] m_pend;
  bit          m_hold;
  int          m_stall_cnt, m_redir_cnt;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_target(br_target), .exc_valid(exc_valid), .eret_valid(eret_valid),
    .epc(epc), .f_pc(f_pc), .ifu_en(ifu_en), .npc(npc), .flush_fd(flush_fd),
    .f_exccode(f_exccode), .state(state), .stall_cnt(stall_cnt),
    .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend_v = 0; m_pend = 0; m_hold = 0; m_stall_cnt = 0; m_redir_cnt = 0;
  endtask

  task automatic idle_inputs();
    stall = 0; br_valid = 0; exc_valid = 0; eret_valid = 0;
    br_target = 32'h0; epc = 32'h0;
  endtask

  // Called with inputs already driven just after a negedge: checks outputs,
  // crosses one rising edge, advances the model, and returns at the next negedge.
  task automatic cycle();
    logic        e_en, e_flush;
    logic [31:0] e_npc;
    logic [4:0]  e_exc;
    int          e_state;
    e_en = 1; e_flush = 0; e_npc = f_pc + 32'd4;
    e_state = m_pend_v ? 2 : (m_hold ? 1 : 0);
    e_exc = (f_pc % 4 != 0 || f_pc < 32'h3000 || f_pc > 32'h6ffc) ? 5'd4 : 5'd0;
    #1;
    if (exc_valid) begin
      e_npc = 32'h4180; e_flush = 1;
    end else if (eret_valid) begin
      e_npc = epc; e_flush = 1;
    end else if (m_pend_v) begin
      if (stall) e_en = 0;
      else e_npc = br_valid ? br_target : m_pend;
    end else if (br_valid) begin
      if (stall) e_en = 0;
      else e_npc = br_target;
    end else if (stall) begin
      e_en = 0;
    end
    check("ifu_en", {31'b0, ifu_en}, {31'b0, e_en});
    check("npc", npc, e_npc);
    check("flush_fd", {31'b0, flush_fd}, {31'b0, e_flush});
    check("f_exccode", {27'b0, f_exccode}, {27'b0, e_exc});
    check("state", {30'b0, state}, e_state);
    check("stall_cnt", {16'b0, stall_cnt}, m_stall_cnt);
    check("redir_cnt", {16'b0, redir_cnt}, m_redir_cnt);
    @(posedge clk);
    if (!e_en && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
    if (exc_valid || eret_valid) begin
      m_redir_cnt = (m_redir_cnt + 1) % 65536;
      m_pend_v = 0; m_hold = 0;
    end else if (m_pend_v) begin
      if (stall) begin
        if (br_valid) m_pend = br_target;
      end else m_pend_v = 0;
    end else if (br_valid && stall) begin
      m_pend_v = 1; m_pend = br_target; m_hold = 0;
    end else begin
      m_hold = stall && !br_valid;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ifu_en"}, {31'b0, ifu_en}, 32'd0);
    check({tag, ".npc"}, npc, 32'h0000_3000);
    check({tag, ".flush_fd"}, {31'b0, flush_fd}, 32'd0);
    check({tag, ".state"}, {30'b0, state}, 32'd0);
    check({tag, ".stall_cnt"}, {16'b0, stall_cnt}, 32'd0);
    check({tag, ".redir_cnt"}, {16'b0, redir_cnt}, 32'd0);
  endtask

  logic [31:0] pc_pool [6];

  initial begin
    int r0;
    pc_pool[0] = 32'h0000_3000; pc_pool[1] = 32'h0000_6ffc; pc_pool[2] = 32'h0000_3002;
    pc_pool[3] = 32'h0000_7000; pc_pool[4] = 32'hFFFF_FFFC; pc_pool[5] = 32'h0000_2ffc;

    idle_inputs();
    f_pc  = 32'h0000_3000;
    reset = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1 check_reset_outputs("rst");
    reset = 0;
    @(negedge clk);

    // sequential fetch right after reset
    f_pc = 32'h3000;
    cycle();
    check("seq.stall_cnt0", {16'b0, stall_cnt}, 32'd0);

    // branch under a 3-cycle stall, released with no new branch
    br_valid = 1; br_target = 32'h3100; stall = 1; f_pc = 32'h3004;
    cycle();
    check("br_hold.state", {30'b0, state}, 32'd2);
    br_valid = 0;
    cycle();
    cycle();
    stall = 0;
    #1 check("br_rel.npc", npc, 32'h3100);
    check("br_rel.en", {31'b0, ifu_en}, 32'd1);
    cycle();
    check("br_rel.state", {30'b0, state}, 32'd0);
    check("br_rel.stall_cnt", {16'b0, stall_cnt}, 32'd3);

    // exception beats stall and branch
    exc_valid = 1; stall = 1; br_valid = 1; br_target = 32'h3200;
    #1 check("exc.npc", npc, 32'h4180);
    check("exc.flush", {31'b0, flush_fd}, 32'd1);
    cycle();
    check("exc.redir", {16'b0, redir_cnt}, 32'd1);
    check("exc.state", {30'b0, state}, 32'd0);
    idle_inputs();

    // eret, then fetch address errors
    eret_valid = 1; epc = 32'h3ffc;
    cycle();
    eret_valid = 0;
    f_pc = 32'h3002; cycle();
    f_pc = 32'h7000; cycle();
    f_pc = 32'hFFFF_FFFC;
    #1 check("wrap.npc", npc, 32'h0);
    check("wrap.exc", {27'b0, f_exccode}, 32'd4);
    cycle();

    // simultaneous exc+eret counts once and goes to the handler
    exc_valid = 1; eret_valid = 1; epc = 32'h5000;
    cycle();
    check("both.redir", {16'b0, redir_cnt}, 32'd3);
    idle_inputs();

    // latest branch wins while held
    br_valid = 1; br_target = 32'h3300; stall = 1; cycle();
    br_target = 32'h3400; cycle();
    br_valid = 0; stall = 0;
    #1 check("latest.npc", npc, 32'h3400);
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r0 = $urandom_range(0, 99);
      stall      = ($urandom_range(0, 99) < 45);
      br_valid   = ($urandom_range(0, 99) < 30);
      br_target  = {$urandom_range(32'h3000, 32'h6fff)} & 32'hFFFF_FFFC;
      exc_valid  = (r0 < 5);
      eret_valid = (r0 >= 3 && r0 < 9);
      epc        = $urandom;
      f_pc       = ($urandom_range(0, 3) == 0) ? pc_pool[$urandom_range(0, 5)] : $urandom;
      cycle();
    end
    idle_inputs();

    // reset pulsed mid-cycle while a branch target is pending
    f_pc = 32'h3010;
    br_valid = 1; br_target = 32'h3800; stall = 1;
    cycle();
    check("pre_rst.state", {30'b0, state}, 32'd2);
    br_valid = 0; stall = 0;
    #2 reset = 1;
    #1 check_reset_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    cycle();
    check("post_rst.state", {30'b0, state}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
